y_signature_collector: RTL and testbench
========================================

Name: y_signature_collector

Overview:
- Downstream consumer of the DUT output bus `y`, instantiated in the testbench alongside `top`.
- Compacts `y` over a fixed window of clock cycles into a 32-bit MISR signature.
- Lets the reference simulation and the synthesized-netlist simulation be compared with one word each, instead of a per-cycle `$strobe` dump.
- Exposes the signature through a valid/ready handshake.

Parameters:
- Y_WIDTH, 117: width of the observed bus `y`.
- SIG_WIDTH, 32: signature width.
- POLY, 32'h04C11DB7: MISR feedback polynomial.
- SEED, 32'hFFFFFFFF: signature value after reset and at the start of each window.
- WARMUP, 2: cycles ignored after `start`, so the DUT can leave its reset-state garbage behind.
- NUM_SAMPLES, 16: cycles compacted per window; must be ≥ 1.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- y  in  Y_WIDTH  DUT output bus being observed.
- start  in  1  begins a window; honoured only in IDLE.
- sig_ready  in  1  consumer accepts the signature.
- sig  out  SIG_WIDTH  current or final signature.
- sig_valid  out  1  high in DONE only.
- busy  out  1  high in WARM or RUN.
- sample_cnt  out  16  number of samples compacted in the current window.

Behaviour:
- Clocking and reset:
  - One clock, `clk`. Reset is synchronous and active-high on `rst`.
  - Reset values: state = IDLE, sig = SEED, sig_valid = 0, busy = 0, sample_cnt = 0, warm counter = 0.
  - Reset asserted mid-window aborts it; no partial signature is presented.
- Fold function (combinational):
  - Zero-pad `y` to a multiple of SIG_WIDTH (117 → 128).
  - XOR all SIG_WIDTH chunks together; chunk 0 = y[31:0].
- MISR step:
  - sig_next = {sig[SIG_WIDTH-2:0],1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : 0) ^ fold(y).
- FSM:
  - IDLE:
    - start=1 → sig ← SEED, sample_cnt ← 0.
    - Next state is WARM if WARMUP > 0, else RUN.
  - WARM:
    - Warm counter increments each cycle.
    - After WARMUP cycles → RUN. `y` is ignored.
  - RUN:
    - Each posedge: sig ← sig_next, sample_cnt++.
    - On the posedge that makes sample_cnt == NUM_SAMPLES → DONE.
  - DONE:
    - sig_valid = 1; sig and sample_cnt held stable.
    - sig_ready=1 → IDLE on the next posedge. sig keeps its final value until the next start.
- Latency:
  - start sampled at posedge t.
  - First `y` sample taken at posedge t+WARMUP+1; last at t+WARMUP+NUM_SAMPLES.
  - sig_valid is high from just after the last sample's posedge.
- Boundary cases:
  - start outside IDLE: ignored, including in DONE.
  - start and sig_ready both high in DONE: return to IDLE; start is dropped.
  - sig_ready in any state other than DONE: ignored.
  - sample_cnt wraps at 16 bits, which is unreachable because NUM_SAMPLES < 65536 is required.
  - `y` carrying X/Z propagates X into sig; that is intended and makes netlist X-pessimism visible.

Optional Feature:
- Macro: SIGCOL_COMPARE_EN.
- When defined:
  - Adds input `sig_expected[SIG_WIDTH-1:0]` and output `sig_mismatch`.
  - sig_mismatch is registered on entry to DONE as (sig_next !== sig_expected), using case inequality so X counts as a mismatch.
  - sig_mismatch holds through DONE and clears on the IDLE transition and on reset.
- When undefined: neither port exists and behaviour is otherwise identical.

Decomposition:
- Package `sigcol_pkg`:
  - State enum {IDLE, WARM, RUN, DONE}.
  - Defaults SIG_WIDTH_D, POLY_D, SEED_D.
  - Localparam function for the padded fold chunk count.
- Sub-module `y_fold`:
  - Purely combinational XOR folder, parameterised by Y_WIDTH and SIG_WIDTH.
  - Reused later on the input-stimulus side.

Test Plan:
- Reset behaviour: rst high for 2 cycles with y random → sig=FFFFFFFF, sig_valid=0, busy=0, sample_cnt=0.
- Zero input, one sample: NUM_SAMPLES=1, WARMUP=0, y=0, start pulse → sig_valid high one cycle after the sample; sig=FB3EE249.
- Single-bit fold: SEED=0, NUM_SAMPLES=1, WARMUP=0, y=117'h1 → sig=00000001. Repeat with y=1<<116 → sig=00100000 (bit 20 of chunk 3).
- Handshake: default parameters with start held high → busy for 18 cycles; sig_valid stays high while sig_ready=0 for 5 cycles; sig is stable throughout; after sig_ready, IDLE is entered and the held start begins a new window.
- Reset mid-RUN: rst at sample 7 → next cycle IDLE, sig=FFFFFFFF, sample_cnt=0, sig_valid never asserts.
- Compare feature: with SIGCOL_COMPARE_EN, NUM_SAMPLES=1, WARMUP=0, y=0:
  - sig_expected=FB3EE249 → sig_mismatch=0.
  - sig_expected=FB3EE248 → sig_mismatch=1.
  - y bit driven X → sig_mismatch=1.

Source files
------------

// File: rtl/sigcol_pkg.sv
// Shared types and defaults for the y-bus signature collector.
//   state_t      : collector FSM states
//   *_D          : default signature width, MISR polynomial and seed
//   CNT_W        : width of the sample and warm-up counters
//   fold_chunks(): number of SIG_WIDTH chunks after zero-padding y
package sigcol_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned SIG_WIDTH_D = 32;
  localparam logic [31:0] POLY_D      = 32'h04C11DB7;
  localparam logic [31:0] SEED_D      = 32'hFFFFFFFF;
  localparam int unsigned CNT_W       = 16;

  // Ceiling division: chunks needed to cover yw bits with sw-bit words.
  function automatic int unsigned fold_chunks(input int unsigned yw, input int unsigned sw);
    return (yw + sw - 1) / sw;
  endfunction

endpackage

// File: rtl/y_fold.sv
// Combinational XOR folder: zero-pads y up to a whole number of SIG_WIDTH
// chunks and XORs all chunks together (chunk 0 = y[SIG_WIDTH-1:0]).
// Ports:
//   y      in  Y_WIDTH    bus to compact
//   fold_c out SIG_WIDTH  XOR of all padded chunks
module y_fold
  import sigcol_pkg::*;
#(
  parameter int unsigned Y_WIDTH   = 117,
  parameter int unsigned SIG_WIDTH = SIG_WIDTH_D
) (
  input  logic [Y_WIDTH-1:0]   y,
  output logic [SIG_WIDTH-1:0] fold_c
);

  localparam int unsigned CHUNKS = fold_chunks(Y_WIDTH, SIG_WIDTH);
  localparam int unsigned PAD_W  = CHUNKS * SIG_WIDTH;

  logic [PAD_W-1:0] y_pad;

  // Zero-extend, then XOR-reduce chunk by chunk.
  always_comb begin
    y_pad  = PAD_W'(y);
    fold_c = '0;
    for (int unsigned i = 0; i < CHUNKS; i++) begin
      fold_c = fold_c ^ y_pad[i*SIG_WIDTH +: SIG_WIDTH];
    end
  end

endmodule

// File: rtl/y_signature_collector.sv
// Compacts the observed bus y over a window of NUM_SAMPLES cycles (after
// WARMUP ignored cycles) into a MISR signature, presented via valid/ready.
// Optional feature macro: SIGCOL_COMPARE_EN adds a registered comparison of
// the final signature against sig_expected.
// Ports:
//   clk          in   clock, all logic on posedge
//   rst          in   synchronous active-high reset
//   y            in   observed bus (Y_WIDTH)
//   start        in   begin a window (honoured in IDLE only)
//   sig_ready    in   consumer accepts the signature (DONE only)
//   sig          out  current / final signature
//   sig_valid    out  high in DONE
//   busy         out  high in WARM or RUN
//   sample_cnt   out  samples compacted in this window
//   sig_expected in   (SIGCOL_COMPARE_EN) reference signature
//   sig_mismatch out  (SIGCOL_COMPARE_EN) final signature differs from reference
module y_signature_collector
  import sigcol_pkg::*;
#(
  parameter int unsigned          Y_WIDTH     = 117,
  parameter int unsigned          SIG_WIDTH   = SIG_WIDTH_D,
  parameter logic [SIG_WIDTH-1:0] POLY        = POLY_D,
  parameter logic [SIG_WIDTH-1:0] SEED        = SEED_D,
  parameter int unsigned          WARMUP      = 2,
  parameter int unsigned          NUM_SAMPLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [Y_WIDTH-1:0]   y,
  input  logic                 start,
  input  logic                 sig_ready,
  output logic [SIG_WIDTH-1:0] sig,
  output logic                 sig_valid,
  output logic                 busy,
  output logic [CNT_W-1:0]     sample_cnt
`ifdef SIGCOL_COMPARE_EN
  ,
  input  logic [SIG_WIDTH-1:0] sig_expected,
  output logic                 sig_mismatch
`endif
);

  state_t               state_q, state_d;
  logic [SIG_WIDTH-1:0] sig_d;
  logic [SIG_WIDTH-1:0] sig_next;
  logic [SIG_WIDTH-1:0] fold_c;
  logic [CNT_W-1:0]     cnt_d;
  logic [CNT_W-1:0]     warm_cnt, warm_d;
  logic                 valid_d, busy_d;
`ifdef SIGCOL_COMPARE_EN
  logic                 mismatch_d;
`endif

  y_fold #(
    .Y_WIDTH  (Y_WIDTH),
    .SIG_WIDTH(SIG_WIDTH)
  ) u_fold (
    .y     (y),
    .fold_c(fold_c)
  );

  // MISR step: shift left, conditional polynomial feedback, inject folded y.
  always_comb begin
    sig_next = {sig[SIG_WIDTH-2:0], 1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : '0) ^ fold_c;
  end

  // Next-state and next-register values.
  always_comb begin
    state_d = state_q;
    sig_d   = sig;
    cnt_d   = sample_cnt;
    warm_d  = warm_cnt;
`ifdef SIGCOL_COMPARE_EN
    mismatch_d = sig_mismatch;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sig_d   = SEED;
          cnt_d   = '0;
          warm_d  = '0;
          state_d = (WARMUP > 0) ? WARM : RUN;
        end
      end
      WARM: begin
        // warm_cnt counts completed warm cycles; y is not sampled here.
        warm_d = warm_cnt + 1'b1;
        if (warm_cnt == CNT_W'(WARMUP - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        sig_d = sig_next;
        cnt_d = sample_cnt + 1'b1;
        if (cnt_d == CNT_W'(NUM_SAMPLES)) begin
          state_d = DONE;
`ifdef SIGCOL_COMPARE_EN
          // Case inequality so an X in the signature reads as a mismatch.
          mismatch_d = (sig_next !== sig_expected);
`endif
        end
      end
      DONE: begin
        // start is deliberately not looked at here.
        if (sig_ready) begin
          state_d = IDLE;
`ifdef SIGCOL_COMPARE_EN
          mismatch_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == WARM) || (state_d == RUN);
    valid_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sig        <= SEED;
      sample_cnt <= '0;
      warm_cnt   <= '0;
      busy       <= 1'b0;
      sig_valid  <= 1'b0;
`ifdef SIGCOL_COMPARE_EN
      sig_mismatch <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sig        <= sig_d;
      sample_cnt <= cnt_d;
      warm_cnt   <= warm_d;
      busy       <= busy_d;
      sig_valid  <= valid_d;
`ifdef SIGCOL_COMPARE_EN
      sig_mismatch <= mismatch_d;
`endif
    end
  end

endmodule

// File: tb/tb_y_signature_collector.sv
// Directed bench for y_signature_collector: three instances (default
// parameters, single-sample window, single-sample window with zero seed).
module tb_y_signature_collector;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Default-parameter instance.
  logic [116:0] y_d;
  logic         start_d, ready_d;
  logic [31:0]  sig_dd;
  logic         valid_d, busy_d;
  logic [15:0]  cnt_d;
  // NUM_SAMPLES=1, WARMUP=0 instance.
  logic [116:0] y_1;
  logic         start_1, ready_1;
  logic [31:0]  sig_1;
  logic         valid_1, busy_1;
  logic [15:0]  cnt_1;
  // NUM_SAMPLES=1, WARMUP=0, SEED=0 instance.
  logic [116:0] y_z;
  logic         start_z, ready_z;
  logic [31:0]  sig_z;
  logic         valid_z, busy_z;
  logic [15:0]  cnt_z;
`ifdef SIGCOL_COMPARE_EN
  logic [31:0]  exp_d, exp_1, exp_z;
  logic         mm_d, mm_1, mm_z;
`endif

  y_signature_collector dut_d (
    .clk(clk), .rst(rst), .y(y_d), .start(start_d), .sig_ready(ready_d),
    .sig(sig_dd), .sig_valid(valid_d), .busy(busy_d), .sample_cnt(cnt_d)
`ifdef SIGCOL_COMPARE_EN
    , .sig_expected(exp_d), .sig_mismatch(mm_d)
`endif
  );

  y_signature_collector #(.WARMUP(0), .NUM_SAMPLES(1)) dut_1 (
    .clk(clk), .rst(rst), .y(y_1), .start(start_1), .sig_ready(ready_1),
    .sig(sig_1), .sig_valid(valid_1), .busy(busy_1), .sample_cnt(cnt_1)
`ifdef SIGCOL_COMPARE_EN
    , .sig_expected(exp_1), .sig_mismatch(mm_1)
`endif
  );

  y_signature_collector #(.WARMUP(0), .NUM_SAMPLES(1), .SEED(32'h0)) dut_z (
    .clk(clk), .rst(rst), .y(y_z), .start(start_z), .sig_ready(ready_z),
    .sig(sig_z), .sig_valid(valid_z), .busy(busy_z), .sample_cnt(cnt_z)
`ifdef SIGCOL_COMPARE_EN
    , .sig_expected(exp_z), .sig_mismatch(mm_z)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next posedge; outputs are then settled for checking.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [116:0] rand_y();
    return 117'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  // Reference fold: bit i of y lands in signature bit i mod 32.
  function automatic logic [31:0] fold_m(input logic [116:0] v);
    logic [31:0] f = '0;
    for (int i = 0; i < 117; i++) f[i % 32] = f[i % 32] ^ v[i];
    return f;
  endfunction

  function automatic logic [31:0] misr_m(input logic [31:0] s, input logic [116:0] v);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ fold_m(v);
  endfunction

  // One-sample window on the zero-seed instance.
  task automatic window_z(input string tag, input logic [116:0] yv, input logic [31:0] exp);
    y_z = yv; start_z = 1'b1;
    tick();
    start_z = 1'b0;
    tick();
    check({tag, "_valid"}, 32'(valid_z), 32'd1);
    check({tag, "_sig"}, sig_z, exp);
    ready_z = 1'b1;
    tick();
    ready_z = 1'b0;
  endtask

  logic [116:0] ys [0:18];
  logic [31:0]  e;
  logic [116:0] yv;
  int           valid_seen;

  initial begin
    rst = 1'b1;
    start_d = 0; ready_d = 0; y_d = rand_y();
    start_1 = 0; ready_1 = 0; y_1 = rand_y();
    start_z = 0; ready_z = 0; y_z = rand_y();
`ifdef SIGCOL_COMPARE_EN
    exp_d = '0; exp_1 = 32'hFB3EE249; exp_z = '0;
`endif
    // Reset with random y on the bus.
    tick();
    y_d = rand_y();
    tick();
    check("rst_sig", sig_dd, 32'hFFFFFFFF);
    check("rst_valid", 32'(valid_d), 32'd0);
    check("rst_busy", 32'(busy_d), 32'd0);
    check("rst_cnt", 32'(cnt_d), 32'd0);
    check("rst_sig_1", sig_1, 32'hFFFFFFFF);
    rst = 1'b0;
    tick();

    // Zero input, single sample.
    y_1 = '0; start_1 = 1'b1;
    tick();
    start_1 = 1'b0;
    check("one_busy", 32'(busy_1), 32'd1);
    check("one_valid_early", 32'(valid_1), 32'd0);
    tick();
    check("one_valid", 32'(valid_1), 32'd1);
    check("one_sig", sig_1, 32'hFB3EE249);
    check("one_cnt", 32'(cnt_1), 32'd1);
    check("one_busy_done", 32'(busy_1), 32'd0);
`ifdef SIGCOL_COMPARE_EN
    check("cmp_match", 32'(mm_1), 32'd0);
`endif
    // start in DONE is ignored; then start+ready drops start.
    y_1 = rand_y(); start_1 = 1'b1;
    tick();
    check("done_start_valid", 32'(valid_1), 32'd1);
    check("done_start_sig", sig_1, 32'hFB3EE249);
    check("done_start_cnt", 32'(cnt_1), 32'd1);
    ready_1 = 1'b1;
    tick();
    start_1 = 1'b0; ready_1 = 1'b0;
    check("ret_valid", 32'(valid_1), 32'd0);
    check("ret_busy", 32'(busy_1), 32'd0);
    check("ret_sig", sig_1, 32'hFB3EE249);
    tick();
    check("dropped_start_busy", 32'(busy_1), 32'd0);

    // Second window: chunk-0 pattern, ready held high (ignored outside DONE).
    y_1 = 117'h12345678; start_1 = 1'b1; ready_1 = 1'b1;
`ifdef SIGCOL_COMPARE_EN
    exp_1 = 32'hE90AB430;
`endif
    tick();
    start_1 = 1'b0;
    tick();
    check("pat_valid", 32'(valid_1), 32'd1);
    check("pat_sig", sig_1, 32'hE90AB431);
`ifdef SIGCOL_COMPARE_EN
    check("cmp_mismatch", 32'(mm_1), 32'd1);
`endif
    tick();
    ready_1 = 1'b0;
    check("pat_ret_valid", 32'(valid_1), 32'd0);
`ifdef SIGCOL_COMPARE_EN
    check("cmp_clear", 32'(mm_1), 32'd0);
`endif

    // Single-bit and multi-chunk folds with a zero seed.
    window_z("fold_b0", 117'h1, 32'h00000001);
    yv = '0; yv[116] = 1'b1;
    window_z("fold_b116", yv, 32'h00100000);
    window_z("fold_chunks", {21'h8, 32'h4, 32'h2, 32'h1}, 32'h0000000F);

    // Default parameters, start held high: 2 warm + 16 sample cycles.
    for (int k = 0; k <= 18; k++) ys[k] = rand_y();
    e = 32'hFFFFFFFF;
    for (int k = 3; k <= 18; k++) e = misr_m(e, ys[k]);
    start_d = 1'b1; ready_d = 1'b0;
    for (int k = 0; k <= 18; k++) begin
      y_d = ys[k];
      tick();
      if (k < 18) begin
        check($sformatf("hs_busy_%0d", k), 32'(busy_d), 32'd1);
        check($sformatf("hs_cnt_%0d", k), 32'(cnt_d), (k < 3) ? 32'd0 : 32'(k - 2));
        check($sformatf("hs_valid_%0d", k), 32'(valid_d), 32'd0);
      end
    end
    check("hs_done_busy", 32'(busy_d), 32'd0);
    check("hs_done_valid", 32'(valid_d), 32'd1);
    check("hs_done_cnt", 32'(cnt_d), 32'd16);
    check("hs_done_sig", sig_dd, e);
    for (int k = 0; k < 5; k++) begin
      y_d = rand_y();
      tick();
      check($sformatf("hs_hold_valid_%0d", k), 32'(valid_d), 32'd1);
      check($sformatf("hs_hold_sig_%0d", k), sig_dd, e);
    end
    ready_d = 1'b1;
    tick();
    ready_d = 1'b0;
    check("hs_idle_valid", 32'(valid_d), 32'd0);
    check("hs_idle_busy", 32'(busy_d), 32'd0);
    check("hs_idle_sig", sig_dd, e);
    tick();
    start_d = 1'b0;
    check("hs_restart_busy", 32'(busy_d), 32'd1);
    check("hs_restart_sig", sig_dd, 32'hFFFFFFFF);
    check("hs_restart_cnt", 32'(cnt_d), 32'd0);

    // Reset once sample 7 has been taken.
    for (int k = 1; k <= 9; k++) begin
      y_d = rand_y();
      tick();
    end
    check("mid_cnt", 32'(cnt_d), 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy", 32'(busy_d), 32'd0);
    check("mid_sig", sig_dd, 32'hFFFFFFFF);
    check("mid_cnt_rst", 32'(cnt_d), 32'd0);
    check("mid_valid", 32'(valid_d), 32'd0);
    valid_seen = 0;
    for (int k = 0; k < 25; k++) begin
      y_d = rand_y();
      tick();
      if (valid_d) valid_seen++;
    end
    check("mid_no_valid", 32'(valid_seen), 32'd0);
    check("mid_stay_idle", 32'(busy_d), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
